// File: rtl/xadc_temp_sampler.sv
// Periodic XADC temperature reader: polls the DRP status register, averages
// 2**AVG_LOG2 codes and converts the mean to signed hundredths of a degree C.
module xadc_temp_sampler #(
  parameter int SAMPLE_DIV = 1_000_000,
  parameter int AVG_LOG2   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [6:0]         daddr,
  output logic               den,
  output logic               dwe,
  output logic [15:0]        di,
  input  logic [15:0]        do_drp,
  input  logic               drdy,
  output logic signed [31:0] temp_x100,
  output logic               temp_valid,
  output logic               drp_err
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;
  localparam int ACC_W  = AVG_LOG2 + 12;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int NSAMP  = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACC,
    CONV
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tickCnt_q;
  logic                tick;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    sampCnt_q, sampCnt_d;
  logic signed [31:0]  temp_q, temp_d;
  logic                err_q, err_d;
  logic [11:0]         avg;
  logic [27:0]         product;
  logic [15:0]         scaled;
  logic signed [31:0]  convTemp;
  logic                unusedLsbs;

  assign daddr      = 7'h00;
  assign dwe        = 1'b0;
  assign di         = 16'h0000;
  assign temp_x100  = temp_q;
  assign drp_err    = err_q;
  assign unusedLsbs = ^do_drp[3:0];

  // Free-running sample-rate divider; ticks arriving outside IDLE are simply lost.
  assign tick = (tickCnt_q == TICK_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
    end else if (tick) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + TICK_W'(1);
    end
  end

  // Fixed-point Kelvin-to-Celsius: code * 503.975 / 4096 - 273.15, scaled by 100.
  assign avg      = 12'(acc_q >> AVG_LOG2);
  assign product  = 28'(avg) * 28'd50398;
  assign scaled   = 16'(product >> 12);
  assign convTemp = signed'(32'(scaled)) - 32'sd27315;

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    acc_d      = acc_q;
    sampCnt_d  = sampCnt_q;
    temp_d     = temp_q;
    err_d      = err_q;
    den        = 1'b0;
    temp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) state_d = REQ;
      end
      REQ: begin
        den       = 1'b1;
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (drdy) begin
          acc_d     = acc_q + ACC_W'(do_drp[15:4]);
          sampCnt_d = sampCnt_q + CNT_W'(1);
          state_d   = ACC;
        end else if (waitCnt_q == WAIT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      ACC: begin
        // Result is loaded on entry to CONV so it is already stable while temp_valid is high.
        if (sampCnt_q == CNT_W'(NSAMP)) begin
          temp_d  = convTemp;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        temp_valid = 1'b1;
        acc_d      = '0;
        sampCnt_d  = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      acc_q     <= '0;
      sampCnt_q <= '0;
      temp_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      acc_q     <= acc_d;
      sampCnt_q <= sampCnt_d;
      temp_q    <= temp_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_xadc_temp_sampler.sv
// Randomised bench for xadc_temp_sampler: a DRP responder feeds codes and a
// sample-queue model predicts every averaged temperature.
module tb_xadc_temp_sampler;

  localparam int SAMPLE_DIV = 40;
  localparam int AVG_LOG2   = 2;
  localparam int TIMEOUT    = 12;
  localparam int NSAMP      = 1 << AVG_LOG2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [6:0]         daddr;
  logic               den;
  logic               dwe;
  logic [15:0]        di;
  logic [15:0]        do_drp = 16'h0000;
  logic               drdy = 1'b0;
  logic signed [31:0] temp_x100;
  logic               temp_valid;
  logic               drp_err;

  int errors = 0;
  int checks = 0;
  int validSeen = 0;
  int validExpected = 0;
  int codes[$];

  always #5 clk = ~clk;

  xadc_temp_sampler #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .AVG_LOG2  (AVG_LOG2),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .daddr     (daddr),
    .den       (den),
    .dwe       (dwe),
    .di        (di),
    .do_drp    (do_drp),
    .drdy      (drdy),
    .temp_x100 (temp_x100),
    .temp_valid(temp_valid),
    .drp_err   (drp_err)
  );

  always @(negedge clk) if (temp_valid === 1'b1) validSeen++;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: mean of the queued codes, then the Kelvin-to-Celsius formula in integers.
  function automatic int refTemp(input int samples[$]);
    longint sum = 0;
    longint p;
    foreach (samples[i]) sum += samples[i];
    p = (sum / NSAMP) * 50398;
    return int'(p / 4096) - 27315;
  endfunction

  task automatic waitDen(output int cycles);
    cycles = 0;
    while (den !== 1'b1 && cycles < SAMPLE_DIV + 10) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input int delay, input logic [11:0] code);
    int c;
    waitDen(c);
    checkOutput("den_seen", den, 1);
    @(negedge clk);
    checkOutput("den_pulse", den, 0);
    repeat (delay) @(negedge clk);
    do_drp = {code, 4'($urandom)};
    drdy   = 1'b1;
    @(negedge clk);
    drdy   = 1'b0;
    do_drp = 16'($urandom);
    codes.push_back(int'(code));
    @(negedge clk);
    if (codes.size() == NSAMP) begin
      checkOutput("valid_latency", temp_valid, 1);
      checkOutput("temp_x100", temp_x100, refTemp(codes));
      validExpected++;
      codes.delete();
    end else begin
      checkOutput("no_valid", temp_valid, 0);
    end
  endtask

  task automatic pulseIdleDrdy(input logic [11:0] code);
    do_drp = {code, 4'h0};
    drdy   = 1'b1;
    @(negedge clk);
    drdy   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int c;
    int k;
    logic [11:0] specCodes[4];
    specCodes = '{12'd2400, 12'd2410, 12'd2420, 12'd2430};

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_den", den, 0);
    checkOutput("rst_temp", temp_x100, 0);
    checkOutput("rst_valid", temp_valid, 0);
    checkOutput("rst_err", drp_err, 0);
    checkOutput("daddr", daddr, 0);
    checkOutput("dwe", dwe, 0);
    checkOutput("di", di, 0);
    rst_n = 1'b1;
    waitDen(c);
    checkOutput("first_den_cycle", c, SAMPLE_DIV);

    foreach (specCodes[i]) applyStimulus(3, specCodes[i]);
    checkOutput("spec_avg_temp", temp_x100, 2399);

    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NSAMP; i++)
        applyStimulus($urandom_range(TIMEOUT - 2, 0), 12'($urandom_range(4095, 0)));

    for (int i = 0; i < NSAMP; i++) applyStimulus(1, 12'd0);
    checkOutput("min_code", temp_x100, -27315);
    pulseIdleDrdy(12'd1234);
    pulseIdleDrdy(12'd7);
    for (int i = 0; i < NSAMP; i++) applyStimulus(2, 12'd4095);
    checkOutput("max_code", temp_x100, 23070);

    waitDen(c);
    checkOutput("to_den", den, 1);
    k = 0;
    while (drp_err !== 1'b1 && k < TIMEOUT + 6) begin
      @(negedge clk);
      k++;
    end
    checkOutput("to_err_set", drp_err, 1);
    checkOutput("to_err_window", (k >= TIMEOUT && k <= TIMEOUT + 2), 1);
    pulseIdleDrdy(12'd999);
    for (int i = 0; i < NSAMP; i++)
      applyStimulus($urandom_range(TIMEOUT - 2, 0), 12'($urandom_range(4095, 0)));
    checkOutput("err_sticky", drp_err, 1);

    applyStimulus(1, 12'd100);
    applyStimulus(1, 12'd200);
    waitDen(c);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    do_drp = 16'hFFF0;
    drdy   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drdy = 1'b0;
    codes.delete();
    repeat (3) @(negedge clk);
    checkOutput("wrst_valid", temp_valid, 0);
    checkOutput("wrst_err", drp_err, 0);
    checkOutput("wrst_temp", temp_x100, 0);
    for (int i = 0; i < NSAMP; i++)
      applyStimulus($urandom_range(TIMEOUT - 2, 0), 12'($urandom_range(4095, 0)));

    repeat (5) @(negedge clk);
    checkOutput("valid_count", validSeen, validExpected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
